// File: rtl/mem_wr_router.sv
// Host write router: selects one of four BRAM targets from the address top bits
// and widens addresses with segment/page shadows snooped from controller writes.
module mem_wr_router #(
  parameter int STM_PAGE_W    = 4,
  parameter int STM_NUM_PAGES = 16,
  parameter int DUTY_PAGE_W   = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     BUS_WE,
  input  logic [15:0]              BUS_ADDR,
  input  logic [15:0]              BUS_DATA,
  output logic                     CTL_WE,
  output logic [13:0]              CTL_ADDR,
  output logic                     MOD_WE,
  output logic [14:0]              MOD_ADDR,
  output logic                     NORMAL_WE,
  output logic [13:0]              NORMAL_ADDR,
  output logic                     STM_WE,
  output logic [14+STM_PAGE_W:0]   STM_ADDR,
  output logic [15:0]              WR_DATA,
  output logic [DUTY_PAGE_W-1:0]   DUTY_PAGE,
  output logic                     PAGE_ERR,
  input  logic                     PAGE_ERR_CLR
);

  localparam logic [13:0] MOD_SEG_REG   = 14'h020;
  localparam logic [13:0] STM_SEG_REG   = 14'h050;
  localparam logic [13:0] STM_PAGE_REG  = 14'h058;
  localparam logic [13:0] DUTY_PAGE_REG = 14'h060;
  localparam logic [STM_PAGE_W:0] PAGE_LIMIT = (STM_PAGE_W+1)'(STM_NUM_PAGES);

  function automatic logic page_valid(input logic [STM_PAGE_W-1:0] page);
    return {1'b0, page} < PAGE_LIMIT;
  endfunction

  logic                  vld_p1;
  logic [1:0]            sel_p1;
  logic [13:0]           waddr_p1;
  logic [15:0]           data_p1;

  logic                  mod_seg;
  logic                  stm_seg;
  logic [STM_PAGE_W-1:0] stm_page;

  logic ctl_hit, mod_hit, normal_hit, stm_sel, stm_hit, stm_drop, routed;

  // Stage 1: capture the host bus every cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) vld_p1 <= 1'b0;
    else        vld_p1 <= BUS_WE;
  end

  always_ff @(posedge CLK) begin
    sel_p1   <= BUS_ADDR[15:14];
    waddr_p1 <= BUS_ADDR[13:0];
    data_p1  <= BUS_DATA;
  end

  assign ctl_hit    = vld_p1 && (sel_p1 == 2'd0);
  assign mod_hit    = vld_p1 && (sel_p1 == 2'd1);
  assign normal_hit = vld_p1 && (sel_p1 == 2'd2);
  assign stm_sel    = vld_p1 && (sel_p1 == 2'd3);
  assign stm_hit    = stm_sel && page_valid(stm_page);
  assign stm_drop   = stm_sel && !page_valid(stm_page);
  assign routed     = ctl_hit || mod_hit || normal_hit || stm_hit;

  // Stage 2: decode against current shadows, register routed outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CTL_WE      <= 1'b0;
      CTL_ADDR    <= '0;
      MOD_WE      <= 1'b0;
      MOD_ADDR    <= '0;
      NORMAL_WE   <= 1'b0;
      NORMAL_ADDR <= '0;
      STM_WE      <= 1'b0;
      STM_ADDR    <= '0;
      WR_DATA     <= '0;
      DUTY_PAGE   <= '0;
      PAGE_ERR    <= 1'b0;
      mod_seg     <= 1'b0;
      stm_seg     <= 1'b0;
      stm_page    <= '0;
    end else begin
      CTL_WE    <= ctl_hit;
      MOD_WE    <= mod_hit;
      NORMAL_WE <= normal_hit;
      STM_WE    <= stm_hit;
      if (routed)     WR_DATA     <= data_p1;
      if (ctl_hit)    CTL_ADDR    <= waddr_p1;
      if (mod_hit)    MOD_ADDR    <= {mod_seg, waddr_p1};
      if (normal_hit) NORMAL_ADDR <= waddr_p1;
      if (stm_hit)    STM_ADDR    <= {stm_seg, stm_page, waddr_p1};
      // Shadows land on the CTL_WE edge so the very next decode already sees them
      if (ctl_hit) begin
        case (waddr_p1)
          MOD_SEG_REG:   mod_seg   <= data_p1[0];
          STM_SEG_REG:   stm_seg   <= data_p1[0];
          STM_PAGE_REG:  stm_page  <= data_p1[STM_PAGE_W-1:0];
          DUTY_PAGE_REG: DUTY_PAGE <= data_p1[DUTY_PAGE_W-1:0];
          default: ;
        endcase
      end
      if (stm_drop)          PAGE_ERR <= 1'b1;
      else if (PAGE_ERR_CLR) PAGE_ERR <= 1'b0;
    end
  end

endmodule
